// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
//
// Shared constants and types for the RC4 decryption datapath. Used by the
// key-schedule stage, the message-decrypt stage and the top level.
//
// Contents:
//   S_DEPTH      - entries in the S permutation memory (256)
//   KEY_BYTES    - secret key length in bytes (3)
//   KEY_W        - secret key width in bits (24)
//   DATA_W       - S-memory data width (8)
//   ADDR_W       - S-memory address width (log2 of S_DEPTH)
//   KEY_IDX_W    - width of the cycling key-byte index (2)
//   ksa_state_t  - key-schedule FSM state encoding
//   next_key_idx - advance the key-byte index, wrapping after the last byte
// ---------------------------------------------------------------------------
package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;
  localparam int KEY_W     = 24;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = $clog2(S_DEPTH);
  localparam int KEY_IDX_W = 2;

  localparam int KSA_STATE_W = 4;

  localparam logic [KEY_IDX_W-1:0] KEY_IDX_LAST = KEY_IDX_W'(KEY_BYTES - 1);

  typedef enum logic [KSA_STATE_W-1:0] {
    KSA_IDLE   = 4'd0,
    KSA_INIT   = 4'd1,
    KSA_ADDR_I = 4'd2,
    KSA_WAIT_I = 4'd3,
    KSA_CAP_I  = 4'd4,
    KSA_ADDR_J = 4'd5,
    KSA_WAIT_J = 4'd6,
    KSA_CAP_J  = 4'd7,
    KSA_WR_I   = 4'd8,
    KSA_WR_J   = 4'd9,
    KSA_DONE   = 4'd10
  } ksa_state_t;

  // Cycling counter 0,1,2,0,... used instead of i mod KEY_BYTES so no divider
  // is ever needed.
  function automatic logic [KEY_IDX_W-1:0] next_key_idx(
    input logic [KEY_IDX_W-1:0] idx
  );
    return (idx == KEY_IDX_LAST) ? '0 : idx + KEY_IDX_W'(1);
  endfunction

endpackage : rc4_pkg

// File: rtl/rc4_key_byte_sel.sv
// ---------------------------------------------------------------------------
// rc4_key_byte_sel
//
// Combinational selection of one byte of the secret key.
// Byte 0 is the most significant byte of secret_key; an index past the last
// key byte returns zero.
//
// Ports:
//   secret_key [KEY_W-1:0]     in   full key
//   key_idx    [KEY_IDX_W-1:0] in   byte index
//   key_byte   [DATA_W-1:0]    out  selected byte
// ---------------------------------------------------------------------------
module rc4_key_byte_sel
  import rc4_pkg::*;
(
  input  logic [KEY_W-1:0]     secret_key,
  input  logic [KEY_IDX_W-1:0] key_idx,
  output logic [DATA_W-1:0]    key_byte
);

  localparam int N_SLOTS = 1 << KEY_IDX_W;

  // One slot per possible index value; slots beyond the key are tied to zero
  // so the mux is fully specified for every index.
  logic [N_SLOTS-1:0][DATA_W-1:0] byte_tbl;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      if (gi < KEY_BYTES) begin : g_key
        assign byte_tbl[gi] = secret_key[KEY_W-1-gi*DATA_W -: DATA_W];
      end else begin : g_pad
        assign byte_tbl[gi] = '0;
      end
    end
  endgenerate

  assign key_byte = byte_tbl[key_idx];

endmodule : rc4_key_byte_sel

// File: rtl/rc4_key_schedule.sv
// ---------------------------------------------------------------------------
// rc4_key_schedule
//
// RC4 key-scheduling stage. On start it (optionally) fills S[i]=i and then
// runs the 256-iteration swap loop
//     j = j + S[i] + key[i mod 3];  swap(S[i], S[j])
// against an external 256x8 S-memory shared with the decrypt stage. finish
// is raised once S holds the scheduled permutation.
//
// Build option:
//   RC4_KSA_INIT_EN - defined: the block performs the S[i]=i fill itself.
//                     undefined: S must already hold the identity.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   level request, only looked at in IDLE and DONE
//   secret_key    in   24-bit key, byte 0 = [23:16]; stable until finish
//   s_read_data   in   S-memory read data (valid two cycles after address)
//   s_address     out  S-memory address (registered)
//   s_write       out  S-memory write enable (decoded from state)
//   s_write_data  out  S-memory write data (registered)
//   finish        out  schedule complete (decoded from state)
// ---------------------------------------------------------------------------
module rc4_key_schedule
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  secret_key,
  input  logic [DATA_W-1:0] s_read_data,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_write,
  output logic [DATA_W-1:0] s_write_data,
  output logic              finish
);

  localparam logic [KSA_STATE_W-1:0] ST_IDLE   = KSA_IDLE;
`ifdef RC4_KSA_INIT_EN
  localparam logic [KSA_STATE_W-1:0] ST_INIT   = KSA_INIT;
`endif
  localparam logic [KSA_STATE_W-1:0] ST_ADDR_I = KSA_ADDR_I;
  localparam logic [KSA_STATE_W-1:0] ST_WAIT_I = KSA_WAIT_I;
  localparam logic [KSA_STATE_W-1:0] ST_CAP_I  = KSA_CAP_I;
  localparam logic [KSA_STATE_W-1:0] ST_ADDR_J = KSA_ADDR_J;
  localparam logic [KSA_STATE_W-1:0] ST_WAIT_J = KSA_WAIT_J;
  localparam logic [KSA_STATE_W-1:0] ST_CAP_J  = KSA_CAP_J;
  localparam logic [KSA_STATE_W-1:0] ST_WR_I   = KSA_WR_I;
  localparam logic [KSA_STATE_W-1:0] ST_WR_J   = KSA_WR_J;
  localparam logic [KSA_STATE_W-1:0] ST_DONE   = KSA_DONE;

  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(S_DEPTH - 1);

  logic [KSA_STATE_W-1:0] state_reg,   state_next;
  logic [ADDR_W-1:0]      i_reg,       i_next;
  logic [ADDR_W-1:0]      j_reg,       j_next;
  logic [KEY_IDX_W-1:0]   key_idx_reg, key_idx_next;
  logic [DATA_W-1:0]      si_reg,      si_next;
  logic [DATA_W-1:0]      sj_reg,      sj_next;
  logic [ADDR_W-1:0]      addr_reg,    addr_next;
  logic [DATA_W-1:0]      wdata_reg,   wdata_next;

  logic [DATA_W-1:0]      key_byte;

  rc4_key_byte_sel u_key_byte_sel (
    .secret_key (secret_key),
    .key_idx    (key_idx_reg),
    .key_byte   (key_byte)
  );

  // -------------------------------------------------------------------------
  // Next-state / next-register logic.
  // The address and write-data registers are loaded on the edge that enters
  // a state, so the value a state drives is already on the port for the
  // whole of that state's cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    key_idx_next = key_idx_reg;
    si_next      = si_reg;
    sj_next      = sj_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          i_next       = '0;
          j_next       = '0;
          key_idx_next = '0;
          addr_next    = '0;
`ifdef RC4_KSA_INIT_EN
          wdata_next   = '0;
          state_next   = ST_INIT;
`else
          state_next   = ST_ADDR_I;
`endif
        end
      end

`ifdef RC4_KSA_INIT_EN
      // Identity fill: one write per cycle, address and data both i.
      ST_INIT: begin
        if (i_reg == LAST_I) begin
          i_next     = '0;
          addr_next  = '0;
          state_next = ST_ADDR_I;
        end else begin
          i_next     = i_reg + ADDR_W'(1);
          addr_next  = i_reg + ADDR_W'(1);
          wdata_next = i_reg + DATA_W'(1);
        end
      end
`endif

      ST_ADDR_I: state_next = ST_WAIT_I;
      ST_WAIT_I: state_next = ST_CAP_I;

      // S[i] arrives now. The j update uses the incoming byte directly so the
      // new j can already be the address while in ADDR_J.
      ST_CAP_I: begin
        si_next    = s_read_data;
        j_next     = j_reg + s_read_data + key_byte;
        addr_next  = j_reg + s_read_data + key_byte;
        state_next = ST_ADDR_J;
      end

      ST_ADDR_J: state_next = ST_WAIT_J;
      ST_WAIT_J: state_next = ST_CAP_J;

      // S[j] arrives; set up the first half of the swap: S[i] <= S[j].
      ST_CAP_J: begin
        sj_next    = s_read_data;
        addr_next  = i_reg;
        wdata_next = s_read_data;
        state_next = ST_WR_I;
      end

      // Second half of the swap: S[j] <= old S[i]. When i==j both writes carry
      // the same byte, which leaves S unchanged as the algorithm requires.
      ST_WR_I: begin
        addr_next  = j_reg;
        wdata_next = si_reg;
        state_next = ST_WR_J;
      end

      ST_WR_J: begin
        i_next       = i_reg + ADDR_W'(1);
        key_idx_next = next_key_idx(key_idx_reg);
        addr_next    = i_reg + ADDR_W'(1);
        state_next   = (i_reg == LAST_I) ? ST_DONE : ST_ADDR_I;
      end

      ST_DONE: begin
        if (!start) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      i_reg       <= '0;
      j_reg       <= '0;
      key_idx_reg <= '0;
      si_reg      <= '0;
      sj_reg      <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      key_idx_reg <= key_idx_next;
      si_reg      <= si_next;
      sj_reg      <= sj_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

  // Strobes come straight from the state register so they cannot glitch.
`ifdef RC4_KSA_INIT_EN
  assign s_write = (state_reg == ST_WR_I) || (state_reg == ST_WR_J) ||
                   (state_reg == ST_INIT);
`else
  assign s_write = (state_reg == ST_WR_I) || (state_reg == ST_WR_J);
`endif
  assign finish       = (state_reg == ST_DONE);
  assign s_address    = addr_reg;
  assign s_write_data = wdata_reg;

endmodule : rc4_key_schedule

// File: doc/rc4_key_schedule.md
# rc4_key_schedule

Key-scheduling stage of the RC4 decryption datapath. It sits directly upstream of the message-decrypt stage and shares the 256×8 S-memory with it. On `start` it optionally fills S[i]=i, then runs the standard 256-iteration swap loop j = j + S[i] + key[i mod 3]. When it raises `finish`, S holds the key-scheduled permutation and the decrypt stage may begin.

## Interface
- Parameters: none. Widths are fixed by package constants.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level request; sampled only in IDLE and DONE.
- `secret_key` input 24: key. Byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]; must be stable from `start` until `finish`.
- `s_read_data` input 8: S-memory read data.
- `s_address` output 8: S-memory address.
- `s_write` output 1: S-memory write enable.
- `s_write_data` output 8: S-memory write data.
- `finish` output 1: schedule complete.

## Operation
- Reset values: `s_address`=0, `s_write`=0, `s_write_data`=0, `finish`=0. Internal `i`, `j`, `key_idx`, `si` and `sj` are 0. State = IDLE.
- `s_write` and `finish` are decoded from the state only, so they are glitch-free. `s_address` and `s_write_data` come from registers.
- Memory contract: the address is presented in cycle n. `s_read_data` is valid for capture at the clock edge ending cycle n+2.
- States and transitions:
  - IDLE: when `start`=1, go to INIT (macro defined) or ADDR_I (macro undefined). Clear i, j and key_idx on entry to the loop.
  - INIT: drive `s_address`=i, `s_write_data`=i, `s_write`=1. Increment i each cycle. After i=255, wrap i to 0 and go to ADDR_I.
  - ADDR_I: drive `s_address`=i, then go to WAIT_I.
  - WAIT_I: wait one cycle, then go to CAP_I.
  - CAP_I: si ← `s_read_data`, then go to ADDR_J.
  - ADDR_J: j ← j + si + key_byte[key_idx] (8-bit, mod 256). Drive `s_address` = the new j. Go to WAIT_J.
  - WAIT_J: wait one cycle, then go to CAP_J.
  - CAP_J: sj ← `s_read_data`, then go to WR_I.
  - WR_I: write `s_address`=i, `s_write_data`=sj, `s_write`=1. Go to WR_J.
  - WR_J: write `s_address`=j, `s_write_data`=si, `s_write`=1. Then i ← i+1 and key_idx ← (key_idx==2) ? 0 : key_idx+1. If the old i was 255 go to DONE, else go to ADDR_I.
  - DONE: `finish`=1. Stay in DONE while `start`=1; return to IDLE when `start`=0.
- key_idx is a 2-bit cycling counter. No division or modulo hardware is used.
- Boundary conditions:
  - i==j: both writes still occur, back to back, with equal data. S is unchanged, which is correct.
  - j wraps mod 256 with no saturation.
  - i wraps to 0 on exit from the loop.
- `start` deasserted mid-run is ignored; the run completes.
- `start` asserted mid-run is ignored.
- `reset_n` low at any time returns the block to IDLE immediately, with all outputs at reset values. Partially written S contents are not restored.

## Timing
- The loop costs 8 cycles per i, i.e. 2048 cycles for 256 iterations.
- INIT costs 256 cycles.
- Start to finish: `start` is sampled high in IDLE at edge 0.
  - Macro defined: `finish`=1 in cycle 2305.
  - Macro undefined: `finish`=1 in cycle 2049.
- Exactly two S writes per loop iteration, in consecutive cycles, with i first.
- `finish` drops one cycle after `start` is sampled low in DONE.

## Configuration
- Macro: `RC4_KSA_INIT_EN`.
- Defined: the INIT state is compiled in, and the block performs the S[i]=i fill itself.
- Undefined: INIT is removed, IDLE goes straight to ADDR_I, and S must be preloaded with the identity by a separate stage. No other behaviour changes.

## Structure
- Shared package `rc4_pkg`:
  - state enum `ksa_state_t`
  - `S_DEPTH`=256
  - `KEY_BYTES`=3
  - `KEY_W`=24
  - `DATA_W`=8
  - These are reused by the decrypt stage and the top level.
- One sub-module, `rc4_key_byte_sel`: combinational; takes `secret_key` and the 2-bit index and returns the 8-bit key byte. Index 3 returns 0.
- Everything else is inline in a single FSM module.

## Test plan
- Macro defined, key 24'h000000:
  - Write 0..255 at addresses 0..255 during INIT.
  - At i=2, writes are (addr 2, data 3) then (addr 3, data 2).
  - At i=3, writes are (3, 5) then (5, 2).
  - `finish` rises at cycle 2305.
- Key 24'h010203, i=0: j becomes 1. Writes are (0, 1) then (1, 0). key_idx is then 1.
- Full run against a software RC4 KSA golden model for key 24'h000249: the bench memory model equals the golden S for all 256 entries.
- Macro undefined, memory preloaded with the identity: no writes occur during the first 2 cycles. `finish` rises at cycle 2049 with the same final S as the defined case.
- Pull `reset_n` low at loop i=100, during WR_I:
  - All outputs go to 0 asynchronously and the state is IDLE.
  - Re-asserting `start` rerun from i=0 produces the golden S.
- Hold `start` high after completion:
  - `finish` stays 1 and no writes occur.
  - Drop `start`: `finish`=0 the next cycle.
  - Re-raise `start`: a new run begins.
